// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state encoding and constants for the serial audio capture block
package i2s_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, SHIFT} state_t;
  localparam logic ALIGN_I2S = 1'b1;
  localparam logic ALIGN_LJ = 1'b0;
  localparam int OUT_W = 32;
endpackage

// File: rtl/i2s_tdm_capture_if.sv
// i2s_tdm_capture_if: valid/ready sample stream carrying a left-justified word and its slot index
interface i2s_tdm_capture_if
  import i2s_pkg::*;
#(
  parameter int NUM_CH = 2
);
  localparam int CW = $clog2(NUM_CH);
  logic [OUT_W-1:0] m_data;
  logic [CW-1:0] m_ch;
  logic m_valid;
  logic m_ready;
  modport master(output m_data, m_ch, m_valid, input m_ready);
  modport slave(input m_data, m_ch, m_valid, output m_ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with a registered head word and wrap-bit pointers
module sync_fifo_fwft #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic wr_en, rd_en, valid_n;
  always_comb begin
    full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    wr_en = push && (!full || pop);
    rd_en = pop && valid;
    wr_ptr_n = wr_ptr + (AW+1)'(wr_en);
    rd_ptr_n = rd_ptr + (AW+1)'(rd_en);
    valid_n = wr_ptr_n != rd_ptr_n;
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end
  // The head register must pick up a word written into the slot it is about to expose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid <= 1'b0;
      dout <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      valid <= valid_n;
      dout <= !valid_n ? '0 :
              (wr_en && wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0]) ? din : mem[rd_ptr_n[AW-1:0]];
    end
  end
endmodule

// File: rtl/i2s_tdm_capture.sv
// i2s_tdm_capture: I2S/TDM deserialiser producing slot-tagged left-justified words
// with frame-error detection and a sticky FIFO overflow flag.
module i2s_tdm_capture
  import i2s_pkg::*;
#(
  parameter int   DATA_W     = 24,
  parameter int   SLOT_W     = 32,
  parameter int   NUM_CH     = 2,
  parameter int   FIFO_DEPTH = 8,
  parameter logic ALIGN      = ALIGN_I2S
) (
  input  logic sck,
  input  logic rst_n,
  input  logic start,
  input  logic ws,
  input  logic sd,
  input  logic clr_ovf,
  output logic overflow,
  output logic frame_err,
  i2s_tdm_capture_if.master m
);
  localparam int CW = $clog2(NUM_CH);
  localparam int BW = $clog2(SLOT_W);
  localparam int WIDTH = OUT_W + CW;
  state_t state, state_n;
  logic ws_d, fedge, last_bit, frame_last, expected, restart, sample, err, word_done, shift_en;
  logic [BW-1:0] bit_cnt, bit_n, cur_bit;
  logic [CW-1:0] slot_cnt, slot_n, cur_slot;
  logic [DATA_W-1:0] sr;
  logic push_q, full, pop;
  logic [WIDTH-1:0] word_q, fifo_dout;
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // Counters hold the index of the bit sampled in the current cycle; an accepted
  // frame edge restarts them, and in left-justified mode that edge is itself bit 0.
  always_comb begin
    fedge = ws_d & ~ws;
    last_bit = bit_cnt == BW'(SLOT_W-1);
    frame_last = last_bit && slot_cnt == CW'(NUM_CH-1);
    expected = ALIGN ? frame_last : (bit_cnt == '0 && slot_cnt == '0);
    state_n = state;
    bit_n = bit_cnt;
    slot_n = slot_cnt;
    cur_bit = bit_cnt;
    cur_slot = slot_cnt;
    sample = 1'b0;
    err = 1'b0;
    restart = 1'b0;
    case (state)
      IDLE: state_n = start ? SYNC : IDLE;
      SYNC: begin
        state_n = fedge ? SHIFT : SYNC;
        restart = fedge;
      end
      SHIFT: begin
        if (fedge && !expected) begin
          err = 1'b1;
          restart = 1'b1;
        end else if (expected && !fedge) begin
          err = 1'b1;
          state_n = SYNC;
          bit_n = '0;
          slot_n = '0;
        end else begin
          sample = 1'b1;
          bit_n = last_bit ? '0 : bit_cnt + 1'b1;
          slot_n = !last_bit ? slot_cnt : frame_last ? '0 : slot_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (restart) begin
      sample = !ALIGN;
      cur_bit = '0;
      cur_slot = '0;
      bit_n = ALIGN ? '0 : BW'(1);
      slot_n = '0;
    end
    shift_en = sample && int'(cur_bit) < DATA_W;
    word_done = sample && cur_bit == BW'(DATA_W-1);
    pop = m.m_valid && m.m_ready;
  end
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      ws_d <= 1'b0;
      bit_cnt <= '0;
      slot_cnt <= '0;
      sr <= '0;
      push_q <= 1'b0;
      word_q <= '0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ws_d <= ws;
      bit_cnt <= bit_n;
      slot_cnt <= slot_n;
      sr <= shift_en ? {sr[DATA_W-2:0], sd} : sr;
      push_q <= word_done;
      word_q <= word_done ? {OUT_W'({sr[DATA_W-2:0], sd}) << (OUT_W-DATA_W), cur_slot} : word_q;
      frame_err <= err;
      overflow <= (push_q && full && !pop) ? 1'b1 : clr_ovf ? 1'b0 : overflow;
    end
  end
  sync_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(sck),
    .rst_n(rst_n),
    .push(push_q),
    .din(word_q),
    .full(full),
    .pop(pop),
    .dout(fifo_dout),
    .valid(m.m_valid)
  );
  assign m.m_data = fifo_dout[WIDTH-1:CW];
  assign m.m_ch = fifo_dout[CW-1:0];
endmodule

// File: tb/tb_i2s_tdm_capture.sv
// tb_i2s_tdm_capture: directed vectors for a default I2S instance and an 8-slot left-justified TDM instance
module tb_i2s_tdm_capture;
  import i2s_pkg::*;
  logic sck = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic ws_a = 1'b1, sd_a = 1'b0, clr_a = 1'b0, ovf_a, fe_a;
  logic ws_b = 1'b1, sd_b = 1'b0, clr_b = 1'b0, ovf_b, fe_b;
  int checks = 0, errors = 0, cyc = 0, fe_a_cnt = 0, fe_b_cnt = 0, lsb_l = 0, lsb_r = 0;
  int lsb_b[8];
  typedef struct {logic [31:0] d; int ch; int cyc;} word_t;
  typedef struct {logic [23:0] l; logic [23:0] r; logic [31:0] exp_l; logic [31:0] exp_r;} vec_t;
  word_t qa[$], qb[$];
  vec_t vecs[4];

  i2s_tdm_capture_if #(.NUM_CH(2)) ifa();
  i2s_tdm_capture_if #(.NUM_CH(8)) ifb();

  i2s_tdm_capture dut_a (
    .sck(sck), .rst_n(rst_n), .start(start), .ws(ws_a), .sd(sd_a),
    .clr_ovf(clr_a), .overflow(ovf_a), .frame_err(fe_a), .m(ifa.master)
  );
  i2s_tdm_capture #(.DATA_W(16), .SLOT_W(32), .NUM_CH(8), .FIFO_DEPTH(8), .ALIGN(ALIGN_LJ)) dut_b (
    .sck(sck), .rst_n(rst_n), .start(start), .ws(ws_b), .sd(sd_b),
    .clr_ovf(clr_b), .overflow(ovf_b), .frame_err(fe_b), .m(ifb.master)
  );

  always #5 sck = ~sck;
  always @(posedge sck) cyc++;

  always @(negedge sck) begin
    word_t w;
    #1;
    if (ifa.m_valid && ifa.m_ready) begin
      w.d = ifa.m_data; w.ch = int'(ifa.m_ch); w.cyc = cyc;
      qa.push_back(w);
    end
    if (ifb.m_valid && ifb.m_ready) begin
      w.d = ifb.m_data; w.ch = int'(ifb.m_ch); w.cyc = cyc;
      qb.push_back(w);
    end
    if (fe_a) fe_a_cnt++;
    if (fe_b) fe_b_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_word(input bit b, input string name, input logic [31:0] d, input int ch, input int c);
    word_t w;
    int n;
    n = b ? qb.size() : qa.size();
    chk({name, "_present"}, 32'(n > 0), 32'd1);
    if (n > 0) begin
      w = b ? qb.pop_front() : qa.pop_front();
      chk({name, "_data"}, w.d, d);
      chk({name, "_ch"}, w.ch, ch);
      if (c >= 0) chk({name, "_cycle"}, w.cyc, c);
    end
  endtask

  task automatic tick_a(input logic w, input logic s, input logic c);
    @(negedge sck);
    ws_a = w; sd_a = s; clr_a = c;
  endtask

  task automatic idle_a(input int n);
    repeat (n) tick_a(1'b1, 1'b0, 1'b0);
  endtask

  task automatic drive_a(input logic [23:0] l, input logic [23:0] r, input int j0, input int j1, input logic c);
    logic [63:0] s;
    s = {l, 8'h00, r, 8'h00};
    for (int j = j0; j <= j1; j++) begin
      tick_a(j >= 32, j == 0 ? 1'b0 : s[64-j], c);
      if (j == 24) lsb_l = cyc + 1;
      if (j == 56) lsb_r = cyc + 1;
    end
  endtask

  task automatic frame_a(input logic [23:0] l, input logic [23:0] r);
    drive_a(l, r, 0, 63, 1'b0);
  endtask

  task automatic frame_b();
    logic [15:0] v;
    for (int j = 0; j < 256; j++) begin
      v = 16'(16'h1000 + j / 32);
      @(negedge sck);
      ws_b = j >= 128;
      sd_b = (j % 32) < 16 ? v[15 - (j % 32)] : 1'b0;
      if (j % 32 == 15) lsb_b[j / 32] = cyc + 1;
    end
  endtask

  task automatic pulse_start();
    @(negedge sck); start = 1'b1;
    @(negedge sck); start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{24'hABCDEF, 24'h123456, 32'hABCDEF00, 32'h12345600};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 32'hFFFFFF00, 32'h00000000};
    vecs[2] = '{24'h800001, 24'h7FFFFE, 32'h80000100, 32'h7FFFFE00};
    vecs[3] = '{24'h000001, 24'h555555, 32'h00000100, 32'h55555500};
    ifa.m_ready = 1'b1;
    ifb.m_ready = 1'b1;
    repeat (3) @(negedge sck);
    chk("rst_valid", 32'(ifa.m_valid), 32'd0);
    chk("rst_data", ifa.m_data, 32'd0);
    chk("rst_ch", 32'(ifa.m_ch), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_ferr", 32'(fe_a), 32'd0);
    chk("rst_b_valid", 32'(ifb.m_valid), 32'd0);
    rst_n = 1'b1;
    pulse_start();

    repeat (3) @(negedge sck);
    frame_b();
    repeat (10) @(negedge sck);
    for (int k = 0; k < 8; k++)
      exp_word(1'b1, "tdm_slot", {16'(16'h1000 + k), 16'h0000}, k, lsb_b[k] + 1);
    chk("tdm_extra", 32'(qb.size()), 32'd0);
    chk("tdm_missing_edge_err", 32'(fe_b_cnt), 32'd1);

    idle_a(2);
    for (int i = 0; i < 4; i++) begin
      frame_a(vecs[i].l, vecs[i].r);
      exp_word(1'b0, "vec_l", vecs[i].exp_l, 0, lsb_l + 1);
      exp_word(1'b0, "vec_r", vecs[i].exp_r, 1, lsb_r + 1);
    end
    chk("good_frames_no_err", 32'(fe_a_cnt), 32'd0);

    drive_a(24'hAAAAAA, 24'h555555, 0, 9, 1'b0);
    tick_a(1'b1, 1'b0, 1'b0);
    frame_a(24'h13579B, 24'h2468AC);
    exp_word(1'b0, "early_l", 32'h13579B00, 0, lsb_l + 1);
    exp_word(1'b0, "early_r", 32'h2468AC00, 1, lsb_r + 1);
    chk("early_no_partial", 32'(qa.size()), 32'd0);
    chk("early_err_pulse", 32'(fe_a_cnt), 32'd1);

    idle_a(10);
    chk("missing_err_pulse", 32'(fe_a_cnt), 32'd2);
    frame_a(24'h0F0F0F, 24'hF0F0F0);
    exp_word(1'b0, "resync_l", 32'h0F0F0F00, 0, lsb_l + 1);
    exp_word(1'b0, "resync_r", 32'hF0F0F000, 1, lsb_r + 1);

    ifa.m_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      frame_a(24'(24'hC00000 + 2 * k + 1), 24'(24'hC00000 + 2 * k + 2));
    chk("full_no_ovf", 32'(ovf_a), 32'd0);
    chk("full_valid", 32'(ifa.m_valid), 32'd1);
    chk("full_head", ifa.m_data, 32'hC0000100);
    drive_a(24'hC00009, 24'hC0000A, 0, 26, 1'b0);
    chk("drop9_ovf", 32'(ovf_a), 32'd1);
    drive_a(24'hC00009, 24'hC0000A, 27, 39, 1'b0);
    drive_a(24'hC00009, 24'hC0000A, 40, 40, 1'b1);
    drive_a(24'hC00009, 24'hC0000A, 41, 41, 1'b0);
    chk("clr_ovf", 32'(ovf_a), 32'd0);
    drive_a(24'hC00009, 24'hC0000A, 42, 56, 1'b0);
    drive_a(24'hC00009, 24'hC0000A, 57, 57, 1'b1);
    drive_a(24'hC00009, 24'hC0000A, 58, 58, 1'b0);
    chk("drop10_beats_clr", 32'(ovf_a), 32'd1);
    drive_a(24'hC00009, 24'hC0000A, 59, 63, 1'b0);
    chk("stall_head_held", ifa.m_data, 32'hC0000100);
    ifa.m_ready = 1'b1;
    idle_a(20);
    for (int i = 1; i <= 8; i++)
      exp_word(1'b0, "fifo_word", {24'(24'hC00000 + i), 8'h00}, (i - 1) % 2, -1);
    chk("fifo_drained", 32'(qa.size()), 32'd0);
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    tick_a(1'b1, 1'b0, 1'b1);
    tick_a(1'b1, 1'b0, 1'b0);
    chk("ovf_cleared", 32'(ovf_a), 32'd0);

    ifa.m_ready = 1'b0;
    frame_a(24'h111111, 24'h222222);
    drive_a(24'h333333, 24'h444444, 0, 45, 1'b0);
    chk("prereset_valid", 32'(ifa.m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ifa.m_valid), 32'd0);
    chk("async_rst_data", ifa.m_data, 32'd0);
    chk("async_rst_ch", 32'(ifa.m_ch), 32'd0);
    chk("async_rst_ferr", 32'(fe_a), 32'd0);
    idle_a(3);
    rst_n = 1'b1;
    ifa.m_ready = 1'b1;
    frame_a(24'h555555, 24'h666666);
    frame_a(24'h777777, 24'h888888);
    idle_a(4);
    chk("unarmed_no_words", 32'(qa.size()), 32'd0);
    chk("unarmed_valid", 32'(ifa.m_valid), 32'd0);
    pulse_start();
    frame_a(24'h314159, 24'h271828);
    exp_word(1'b0, "rearm_l", 32'h31415900, 0, lsb_l + 1);
    exp_word(1'b0, "rearm_r", 32'h27182800, 1, lsb_r + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
